// File: rtl/sms_sram_init_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : sms_sram_init_ctrl_pkg
// Brief  : Shared types and helpers for the SMS SRAM init sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package sms_sram_init_ctrl_pkg;

  // Sequencer states (2-bit encoding shared with the SMS block)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_FILL  = 2'd3
  } state_t;

  // Bus byte enables are little-endian (be[k] -> bits [8k+7:8k]) while the
  // SPRAM lanes are numbered from the top byte down, so the bits are mirrored.
  function automatic logic [3:0] be_to_lane_we(input logic [3:0] be);
    return {be[0], be[1], be[2], be[3]};
  endfunction

endpackage : sms_sram_init_ctrl_pkg
`default_nettype wire

// File: rtl/sms_sram_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sms_sram_init_ctrl
// Brief  : Init sequencer for the SMS byte-lane SPRAM. Zero-clears the array
//          or streams in a program image and zero-fills the remainder; bus
//          accesses are held off until init finishes, then passed through.
// Rev    : 1.0  initial release
// ============================================================================
module sms_sram_init_ctrl
  import sms_sram_init_ctrl_pkg::*;
#(
  parameter int AW         = 14,
  parameter bit AUTO_CLEAR = 1'b1
) (
  input  logic          hclk,
  input  logic          hresetn,
  // init control
  input  logic          init_start,
  input  logic          init_mode,
  input  logic [AW:0]   init_len,
  // load stream
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  output logic          ld_ready,
  // bus side
  input  logic          bus_req,
  input  logic          bus_we,
  input  logic [3:0]    bus_be,
  input  logic [AW-1:0] bus_addr,
  input  logic [31:0]   bus_wdata,
  output logic          bus_gnt,
  output logic [31:0]   bus_rdata,
  output logic          bus_rvalid,
  // SRAM side
  output logic          ram_cs,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  // status
  output logic          init_busy,
  output logic          init_done
);

  localparam logic [AW-1:0] LAST_ADDR = '1;
  // Full-array load length; such a load has nothing left to zero-fill.
  localparam logic [AW:0]   FULL_LEN  = {1'b1, {AW{1'b0}}};
  localparam state_t        RST_STATE = AUTO_CLEAR ? ST_CLEAR : ST_IDLE;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [AW:0]   len, len_nxt;
  logic          done, done_nxt;
  logic          rvalid;

  // State, address counter, captured length and sticky done flag
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state <= RST_STATE;
      cnt   <= '0;
      len   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      len   <= len_nxt;
      done  <= done_nxt;
    end
  end

  // Read data is valid exactly one cycle after a granted read
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      rvalid <= 1'b0;
    end else begin
      rvalid <= bus_gnt & ~bus_we;
    end
  end

  // Next-state logic and the SRAM port mux (bus passthrough vs. init writes)
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len;
    done_nxt  = done;
    ram_cs    = 1'b0;
    ram_we    = 4'h0;
    ram_addr  = cnt;
    ram_wdata = '0;
    ld_ready  = 1'b0;
    bus_gnt   = 1'b0;

    case (state)
      ST_IDLE: begin
        // Bus owns the SRAM in IDLE, even in the cycle a start is accepted.
        bus_gnt   = bus_req;
        ram_cs    = bus_req;
        ram_addr  = bus_addr;
        ram_wdata = bus_wdata;
        ram_we    = {4{bus_req & bus_we}} & be_to_lane_we(bus_be);
        if (init_start) begin
          done_nxt = 1'b0;
          len_nxt  = init_len;
          cnt_nxt  = '0;
          if (!init_mode) begin
            state_nxt = ST_CLEAR;
          end else if (init_len != '0) begin
            state_nxt = ST_LOAD;
          end else begin
            state_nxt = ST_FILL;
          end
        end
      end

      ST_CLEAR, ST_FILL: begin
        // FILL differs from CLEAR only in its starting address (= len).
        ram_cs  = 1'b1;
        ram_we  = 4'hF;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_ADDR) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end

      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          ram_cs    = 1'b1;
          ram_we    = 4'hF;
          ram_wdata = ld_data;
          cnt_nxt   = cnt + 1'b1;
          if ({1'b0, cnt} == len - 1'b1) begin
            if (len == FULL_LEN) begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = ST_FILL;
            end
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // While reset is asserted nothing touches the SRAM or the handshakes.
    if (!hresetn) begin
      ram_cs   = 1'b0;
      ram_we   = 4'h0;
      ld_ready = 1'b0;
      bus_gnt  = 1'b0;
    end
  end

  assign bus_rdata  = ram_rdata;
  assign bus_rvalid = rvalid;
  assign init_busy  = (state != ST_IDLE);
  assign init_done  = done;

endmodule : sms_sram_init_ctrl
`default_nettype wire
